// File: rtl/mic_pkg.sv
// Shared types and widths for the mic sample path.
// Latency: n/a (types only). Backpressure: n/a.
package mic_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int DROP_CNT_W = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Increment that sticks at all-ones so the drop counter never wraps back to a small value.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction
endpackage

// File: rtl/mic_fifo_mem.sv
// DEPTH x W storage with one synchronous write port and one asynchronous read port.
// Latency: write visible on read port the cycle after we. Backpressure: none, caller gates we.
module mic_fifo_mem #(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mic_frame_fifo.sv
// Buffers deserialised mic samples into a FWFT valid/ready stream and tags frame ends.
// Latency: 1 cycle write-to-out_valid. Backpressure: samples arriving while full are dropped and counted.
module mic_frame_fifo
    import mic_pkg::*;
#(
    parameter int N         = SAMPLE_W,
    parameter int DEPTH     = 64,
    parameter int FRAME_LEN = 32
) (
    input  logic                       bclk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic [N-1:0]               sample_data,
    input  logic                       flush,
    input  logic                       clr_overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [DROP_CNT_W-1:0]      drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int FP_W  = $clog2(FRAME_LEN);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [FP_W-1:0]  FP_LAST  = FP_W'(FRAME_LEN - 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [FP_W-1:0]  frame_pos;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    // flush wins over everything; a sample coinciding with it is silently discarded.
    assign full      = (level == FULL_LVL);
    assign push      = sample_valid && !flush && !full;
    assign drop      = sample_valid && !flush && full;
    assign pop       = out_valid && out_ready && !flush;

    assign out_valid = (level != '0);
    assign out_last  = out_valid && (frame_pos == FP_LAST);

    mic_fifo_mem #(
        .W     (N),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (bclk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (sample_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            frame_pos  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                frame_pos <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                    frame_pos <= (frame_pos == FP_LAST) ? '0 : frame_pos + FP_W'(1);
                end
                case ({push, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end

            // A drop in the same cycle as clr_overflow leaves a fresh count of one.
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= clr_overflow ? DROP_CNT_W'(1) : sat_inc(drop_count);
            end else if (clr_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mic_frame_fifo.sv
// Directed bench for mic_frame_fifo: a scoreboard queue of expected {last,data} drained by a monitor.
module tb_mic_frame_fifo;
    import mic_pkg::*;

    logic        bclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        flush = 1'b0;
    logic        clr_overflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic [6:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb [$];

    mic_frame_fifo #(.N(16), .DEPTH(64), .FRAME_LEN(32)) dut (
        .bclk         (bclk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic push_sample(input logic [15:0] d, input bit expect_out, input bit last);
        sample_valid = 1'b1;
        sample_data  = d;
        if (expect_out) sb.push_back({last, d});
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (level != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        out_ready = 1'b0;
        check({name, "_drained"}, level, 0);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: a handshake seen at the falling edge is accepted at the next rising edge.
    initial begin
        logic [16:0] exp;
        forever begin
            @(negedge bclk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got data 0x%0h last %0b, expected nothing", out_data, out_last);
                end else begin
                    exp = sb.pop_front();
                    if ({out_last, out_data} !== exp) begin
                        errors++;
                        $display("FAIL stream: got data 0x%0h last %0b expected data 0x%0h last %0b",
                                 out_data, out_last, exp[15:0], exp[16]);
                    end
                end
            end
        end
    end

    initial begin
        // Reset values
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        rst_n = 1'b1;
        tick();

        // 1: push three with consumer stalled
        sample_valid = 1'b1;
        sample_data  = 16'h0001;
        sb.push_back({1'b0, 16'h0001});
        check("t1_valid_before_edge", out_valid, 0);
        tick();
        sample_valid = 1'b0;
        check("t1_valid_after_1cyc", out_valid, 1);
        check("t1_head_first", out_data, 16'h0001);
        push_sample(16'h0002, 1'b1, 1'b0);
        push_sample(16'h0003, 1'b1, 1'b0);
        check("t1_level", level, 3);
        check("t1_head", out_data, 16'h0001);
        check("t1_last", out_last, 0);
        drain("t1");
        do_reset();

        // 2: steady consumer, 64 samples, frame end at 31 and 63
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            push_sample(16'(i), 1'b1, (i % 32) == 31);
            repeat (3) tick();
        end
        out_ready = 1'b0;
        check("t2_sb_empty", sb.size(), 0);
        check("t2_level", level, 0);

        // 3: overfill by six
        for (int i = 0; i < 70; i++) begin
            push_sample(16'(16'h0100 + i), i < 64, (i % 32) == 31);
        end
        check("t3_level_full", level, 64);
        check("t3_overflow", overflow, 1);
        check("t3_drop_count", drop_count, 6);
        drain("t3");

        // 4: full FIFO, pop and push in the same cycle -> push still dropped
        for (int i = 0; i < 64; i++) begin
            push_sample(16'(16'h0200 + i), 1'b1, (i % 32) == 31);
        end
        out_ready    = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 16'hDEAD;
        tick();
        out_ready    = 1'b0;
        sample_valid = 1'b0;
        check("t4_level", level, 63);
        check("t4_drop_count", drop_count, 7);
        check("t4_head", out_data, 16'h0201);
        drain("t4");

        // 5: flush with 10 entries and a coincident sample
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_sample(16'(16'h0300 + i), 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_sample(16'(16'h0400 + i), 1'b0, 1'b0);
        check("t5_level_pre", level, 10);
        flush        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 16'h7777;
        tick();
        flush        = 1'b0;
        sample_valid = 1'b0;
        check("t5_level", level, 0);
        check("t5_valid", out_valid, 0);
        check("t5_drop_count", drop_count, 7);
        check("t5_overflow", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) push_sample(16'(16'h0500 + i), 1'b1, i == 31);
        tick();
        out_ready = 1'b0;
        check("t5_sb_empty", sb.size(), 0);

        // 6: clr_overflow alone, then coincident with a drop, then async reset mid-stream
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t6_clr_overflow", overflow, 0);
        check("t6_clr_count", drop_count, 0);
        for (int i = 0; i < 64; i++) push_sample(16'(16'h0600 + i), 1'b0, 1'b0);
        clr_overflow = 1'b1;
        push_sample(16'hBEEF, 1'b0, 1'b0);
        clr_overflow = 1'b0;
        check("t6_drop_wins_flag", overflow, 1);
        check("t6_drop_wins_count", drop_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_arst_valid", out_valid, 0);
        check("t6_arst_level", level, 0);
        check("t6_arst_overflow", overflow, 0);
        check("t6_arst_count", drop_count, 0);
        check("t6_arst_last", out_last, 0);
        #10;
        rst_n = 1'b1;
        tick();
        push_sample(16'h0A0A, 1'b1, 1'b0);
        check("t6_post_rst_level", level, 1);
        check("t6_post_rst_head", out_data, 16'h0A0A);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
